// File: rtl/nebula_credit_tx.sv
// Credit-based NoC link transmitter: pops flits from a show-ahead FIFO and
// launches registered beats while holding receiver credits.
module nebula_credit_tx #(
  parameter int WIDTH   = 16,
  parameter int CREDITS = 8,
  localparam int CW     = $clog2(CREDITS) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             fifo_pop,
  output logic             link_valid,
  output logic [WIDTH-1:0] link_data,
  input  logic             credit_ret,
  output logic [CW-1:0]    credits,
  output logic             cred_err,
  output logic [15:0]      stall_cnt
);

  localparam logic [CW-1:0] CMAX = CW'(CREDITS);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic             pending;
  logic             send;
  logic             link_valid_q, link_valid_d;
  logic [WIDTH-1:0] link_data_q,  link_data_d;
  logic [CW-1:0]    credits_q,    credits_d;
  logic             cred_err_q,   cred_err_d;
  logic [15:0]      stall_cnt_q,  stall_cnt_d;

  always_comb begin
    pending = en & ~fifo_empty;
    // Gated by rst_n so no flit is consumed from the FIFO while held in reset.
    send    = rst_n & pending & (credits_q != '0);

    link_valid_d = send;
    link_data_d  = send ? fifo_dout : link_data_q;

    credits_d  = credits_q;
    cred_err_d = cred_err_q;
    case ({send, credit_ret})
      2'b10:   credits_d = credits_q - ONE;
      2'b01: begin
        if (credits_q == CMAX) cred_err_d = 1'b1;
        else                   credits_d  = credits_q + ONE;
      end
      default: ;
    endcase

    stall_cnt_d = stall_cnt_q;
    if (pending && (credits_q == '0) && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_valid_q <= 1'b0;
      link_data_q  <= '0;
      credits_q    <= CMAX;
      cred_err_q   <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      link_valid_q <= link_valid_d;
      link_data_q  <= link_data_d;
      credits_q    <= credits_d;
      cred_err_q   <= cred_err_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign fifo_pop   = send;
  assign link_valid = link_valid_q;
  assign link_data  = link_data_q;
  assign credits    = credits_q;
  assign cred_err   = cred_err_q;
  assign stall_cnt  = stall_cnt_q;

endmodule
